// File: rtl/goal_detector_if.sv
// Referee bus: ball and goal geometry plus the kickoff / restart handshake in,
// scores and game-state flags out.
interface goal_detector_if;
   logic [9:0] BallX, BallY, BallS;
   logic [9:0] LGoalX, LGoalY, LGoalSX, LGoalSY;
   logic [9:0] RGoalX, RGoalY, RGoalSX, RGoalSY;
   logic       KickoffAck;
   logic       NewGame;
   logic [3:0] ScoreL, ScoreR;
   logic       GoalPulse;
   logic       GoalSide;
   logic       Freeze;
   logic       KickoffReq;
   logic       GameOver;
   logic       Winner;

   modport master (
      output BallX, BallY, BallS,
      output LGoalX, LGoalY, LGoalSX, LGoalSY,
      output RGoalX, RGoalY, RGoalSX, RGoalSY,
      output KickoffAck, NewGame,
      input  ScoreL, ScoreR, GoalPulse, GoalSide, Freeze, KickoffReq, GameOver, Winner
   );

   modport slave (
      input  BallX, BallY, BallS,
      input  LGoalX, LGoalY, LGoalSX, LGoalSY,
      input  RGoalX, RGoalY, RGoalSX, RGoalSY,
      input  KickoffAck, NewGame,
      output ScoreL, ScoreR, GoalPulse, GoalSide, Freeze, KickoffReq, GameOver, Winner
   );
endinterface

// File: rtl/goal_detector.sv
// Per-frame scoring referee: confirms goals over consecutive frames, keeps the
// score, and sequences freeze / kickoff / game-over.
module goal_detector #(
   parameter int CONFIRM_FRAMES = 3,
   parameter int FREEZE_FRAMES  = 120,
   parameter int WIN_SCORE      = 5
) (
   input  logic           frame_clk,
   input  logic           Reset,
   goal_detector_if.slave io
);

   typedef enum logic [2:0] {PLAY, CONFIRM, FREEZE, KICKOFF, GAMEOVER} state_t;

   state_t     state, state_nx;
   logic [3:0] count, count_nx;
   logic [7:0] ftimer, ftimer_nx;
   logic       side, side_nx;
   logic [3:0] score_l, score_l_nx, score_r, score_r_nx;
   logic       goal_side, goal_side_nx;
   logic       winner, winner_nx;
   logic       pulse, pulse_nx;
   logic       freeze, kreq, gover;
   logic       in_l, in_r, hit_l, hit_r, hit_latched;

   // Goal top edge (Y - SY), clamped at zero so the comparison never wraps.
   function automatic logic [10:0] top_edge(input logic [9:0] y, input logic [9:0] sy);
      return (y >= sy) ? ({1'b0, y} - {1'b0, sy}) : 11'd0;
   endfunction

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s >= 4'(WIN_SCORE)) ? s : s + 4'd1;
   endfunction

   // Subtractions are moved to the other side as sums, so a ball near 0 never underflows.
   assign in_l = (({1'b0, io.BallX} + {1'b0, io.BallS}) < ({1'b0, io.LGoalX} + {1'b0, io.LGoalSX}))
              && ({1'b0, io.BallY} > ({1'b0, io.BallS} + top_edge(io.LGoalY, io.LGoalSY)))
              && (io.BallY <= io.LGoalY);
   assign in_r = ({1'b0, io.BallX} > ({1'b0, io.BallS} + {1'b0, io.RGoalX}))
              && ({1'b0, io.BallY} > ({1'b0, io.BallS} + top_edge(io.RGoalY, io.RGoalSY)))
              && (io.BallY <= io.RGoalY);

   assign hit_l       = in_l;
   assign hit_r       = in_r & ~in_l;
   assign hit_latched = side ? hit_r : hit_l;

   always_comb begin
      state_nx     = state;
      count_nx     = count;
      ftimer_nx    = ftimer;
      side_nx      = side;
      score_l_nx   = score_l;
      score_r_nx   = score_r;
      goal_side_nx = goal_side;
      winner_nx    = winner;
      pulse_nx     = 1'b0;
      case (state)
         PLAY: begin
            if (hit_l || hit_r) begin
               state_nx = CONFIRM;
               side_nx  = hit_r;
               count_nx = 4'd1;
            end
         end
         CONFIRM: begin
            if (!hit_latched) begin
               state_nx = PLAY;
               count_nx = 4'd0;
            end else if (({1'b0, count} + 5'd1) == 5'(CONFIRM_FRAMES)) begin
               count_nx     = 4'd0;
               ftimer_nx    = 8'd0;
               pulse_nx     = 1'b1;
               goal_side_nx = side;
               state_nx     = FREEZE;
               // Ball in the left goal scores for the right player, and vice versa.
               if (!side) begin
                  score_r_nx = sat_inc(score_r);
                  if (score_r_nx == 4'(WIN_SCORE)) begin
                     state_nx  = GAMEOVER;
                     winner_nx = 1'b1;
                  end
               end else begin
                  score_l_nx = sat_inc(score_l);
                  if (score_l_nx == 4'(WIN_SCORE)) begin
                     state_nx  = GAMEOVER;
                     winner_nx = 1'b0;
                  end
               end
            end else begin
               count_nx = count + 4'd1;
            end
         end
         FREEZE: begin
            if (({1'b0, ftimer} + 9'd1) == 9'(FREEZE_FRAMES)) begin
               state_nx  = KICKOFF;
               ftimer_nx = 8'd0;
            end else begin
               ftimer_nx = ftimer + 8'd1;
            end
         end
         KICKOFF: begin
            if (io.KickoffAck) state_nx = PLAY;
         end
         GAMEOVER: begin
            if (io.NewGame) begin
               score_l_nx = 4'd0;
               score_r_nx = 4'd0;
               winner_nx  = 1'b0;
               state_nx   = KICKOFF;
            end
         end
         default: state_nx = PLAY;
      endcase
   end

   // Outputs are registered from the next-state decode so they change on the same edge as the state.
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state     <= PLAY;
         count     <= 4'd0;
         ftimer    <= 8'd0;
         side      <= 1'b0;
         score_l   <= 4'd0;
         score_r   <= 4'd0;
         goal_side <= 1'b0;
         winner    <= 1'b0;
         pulse     <= 1'b0;
         freeze    <= 1'b0;
         kreq      <= 1'b0;
         gover     <= 1'b0;
      end else begin
         state     <= state_nx;
         count     <= count_nx;
         ftimer    <= ftimer_nx;
         side      <= side_nx;
         score_l   <= score_l_nx;
         score_r   <= score_r_nx;
         goal_side <= goal_side_nx;
         winner    <= winner_nx;
         pulse     <= pulse_nx;
         freeze    <= (state_nx == FREEZE) || (state_nx == KICKOFF) || (state_nx == GAMEOVER);
         kreq      <= (state_nx == KICKOFF);
         gover     <= (state_nx == GAMEOVER);
      end
   end

   assign io.ScoreL     = score_l;
   assign io.ScoreR     = score_r;
   assign io.GoalPulse  = pulse;
   assign io.GoalSide   = goal_side;
   assign io.Freeze     = freeze;
   assign io.KickoffReq = kreq;
   assign io.GameOver   = gover;
   assign io.Winner     = winner;

endmodule
